// File: rtl/miriscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miriscv_pkg : shared owner enum and response record for the arbiter   |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package miriscv_pkg;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } resp_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage
`default_nettype wire

// File: rtl/miriscv_arb_starve.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miriscv_arb_starve : saturating count of cycles the I-port was denied |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module miriscv_arb_starve
  import miriscv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic starved_o
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/miriscv_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miriscv_mem_arbiter : I/D port arbiter onto one single-cycle RAM port |
// | Revision            : 1.0                                             |
// +----------------------------------------------------------------------+
module miriscv_mem_arbiter
  import miriscv_pkg::*;
#(
  parameter int unsigned RAM_SIZE     = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic        i_err_o,
  output logic [31:0] i_rdata_o,

  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic        d_err_o,
  output logic [31:0] d_rdata_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [31:0] RAM_END = 32'(RAM_SIZE);

  logic        starved;
  logic        win_i;
  logic        win_d;
  logic        win_any;
  logic [31:0] sel_addr;
  logic        in_range;
  resp_t       resp_q;
  resp_t       resp_d;
  logic        rd_q;
  logic        rd_d;
  logic        rsp_live;
  logic [31:0] rsp_data;

  miriscv_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (i_req_i),
    .gnt_i     (win_i),
    .starved_o (starved)
  );

  always_comb begin
    win_i    = !rst_i && i_req_i && (!d_req_i || starved);
    win_d    = !rst_i && d_req_i && !win_i;
    win_any  = win_i || win_d;
    sel_addr = win_i ? i_addr_i : d_addr_i;
    in_range = sel_addr < RAM_END;
  end

  assign i_gnt_o = win_i;
  assign d_gnt_o = win_d;

  // Out-of-range grants still complete, but must not touch the RAM.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = 32'h0;
    ram_wdata_o = 32'h0;
    if (win_any && in_range) begin
      ram_req_o  = 1'b1;
      ram_addr_o = sel_addr;
      if (win_d) begin
        ram_we_o    = d_we_i;
        ram_be_o    = d_be_i;
        ram_wdata_o = d_wdata_i;
      end else begin
        ram_be_o = BE_WORD;
      end
    end
  end

  always_comb begin
    resp_d.valid = win_any;
    resp_d.owner = win_i ? OWNER_I : OWNER_D;
    resp_d.err   = win_any && !in_range;
    rd_d         = win_any && (win_i || !d_we_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q <= '0;
      rd_q   <= 1'b0;
    end else begin
      resp_q <= resp_d;
      rd_q   <= rd_d;
    end
  end

  // Gating with rst_i drops a response whose grant preceded reset.
  always_comb begin
    rsp_live   = resp_q.valid && !rst_i;
    rsp_data   = (rsp_live && !resp_q.err && rd_q) ? ram_rdata_i : 32'h0;
    i_rvalid_o = rsp_live && (resp_q.owner == OWNER_I);
    d_rvalid_o = rsp_live && (resp_q.owner == OWNER_D);
    i_err_o    = i_rvalid_o && resp_q.err;
    d_err_o    = d_rvalid_o && resp_q.err;
    i_rdata_o  = i_rvalid_o ? rsp_data : 32'h0;
    d_rdata_o  = d_rvalid_o ? rsp_data : 32'h0;
  end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_miriscv_mem_arbiter : scoreboard bench with a behavioural RAM/model |
// | Revision               : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_miriscv_mem_arbiter;

  localparam int RAM_SIZE     = 256;
  localparam int STARVE_LIMIT = 4;
  localparam int RAM_WORDS    = RAM_SIZE / 4;
  localparam int AW           = $clog2(RAM_WORDS);

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [3:0]  d_be_i = '0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        ram_req_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;

  miriscv_mem_arbiter #(
    .RAM_SIZE     (RAM_SIZE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_gnt_o     (i_gnt_o),
    .i_rvalid_o  (i_rvalid_o),
    .i_err_o     (i_err_o),
    .i_rdata_o   (i_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_be_i      (d_be_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_err_o     (d_err_o),
    .d_rdata_o   (d_rdata_o),
    .ram_req_o   (ram_req_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural single-port RAM: read data appears the cycle after the request.
  logic [31:0] ram_mem [0:RAM_WORDS-1];
  logic [31:0] gold    [0:RAM_WORDS-1];
  logic        load_en = 1'b1;

  always @(posedge clk) begin
    if (load_en) begin
      for (int w = 0; w < RAM_WORDS; w++) ram_mem[w] <= gold[w];
      ram_rdata_i <= $urandom;
    end else if (ram_req_o && ram_addr_o < RAM_SIZE) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[AW+1:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
        ram_rdata_i <= $urandom;
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o[AW+1:2]];
      end
    end else begin
      ram_rdata_i <= $urandom;
    end
  end

  typedef struct {
    int          due;
    bit          is_d;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  // Monitor: exactly one response per grant, on the owner's port, one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      if (rst_i) begin
        chk("rst_drop_i_rvalid", {31'd0, i_rvalid_o}, 32'd0);
        chk("rst_drop_d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
      end else begin
        chk("owner_rvalid", {31'd0, e.is_d ? d_rvalid_o : i_rvalid_o}, 32'd1);
        chk("other_rvalid", {31'd0, e.is_d ? i_rvalid_o : d_rvalid_o}, 32'd0);
        chk("rsp_err",      {31'd0, e.is_d ? d_err_o : i_err_o}, {31'd0, e.err});
        chk("rsp_rdata",    e.is_d ? d_rdata_o : i_rdata_o, e.data);
        chk("other_err",    {31'd0, e.is_d ? i_err_o : d_err_o}, 32'd0);
        chk("other_rdata",  e.is_d ? i_rdata_o : d_rdata_o, 32'd0);
      end
    end else begin
      chk("idle_i_rvalid", {31'd0, i_rvalid_o}, 32'd0);
      chk("idle_d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    end
  end

  // Pending requests, held until granted.
  bit          ip = 0, dp = 0, dwe = 0, rst_v = 1;
  logic [31:0] ia = '0, da = '0, dwd = '0;
  logic [3:0]  dbe = '0;
  int          lost = 0;
  int          d_streak = 0;
  int          last_streak = -1;

  task automatic set_i(input logic [31:0] a);
    ip = 1; ia = a;
  endtask

  task automatic set_d(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    dp = 1; dwe = we; dbe = be; da = a; dwd = wd;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return 32'(RAM_SIZE);
      1:       return 32'hFFFF_FFFC;
      2:       return 32'(RAM_SIZE - 1);
      3:       return $urandom | 32'h8000_0000;
      default: return 32'($urandom_range(0, RAM_WORDS - 1) * 4);
    endcase
  endfunction

  task automatic cycle();
    bit          ei, ed, inr;
    logic [31:0] a;
    exp_t        e;
    @(posedge clk);
    #1;
    rst_i     = rst_v;
    i_req_i   = ip;
    i_addr_i  = ia;
    d_req_i   = dp;
    d_we_i    = dwe;
    d_be_i    = dbe;
    d_addr_i  = da;
    d_wdata_i = dwd;
    @(negedge clk);
    if (rst_i) begin
      chk("rst_i_gnt", {31'd0, i_gnt_o}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt_o}, 32'd0);
      chk("rst_ram_req", {31'd0, ram_req_o}, 32'd0);
      lost     = 0;
      d_streak = 0;
    end else begin
      ei = ip && (!dp || lost >= STARVE_LIMIT);
      ed = dp && !ei;
      chk("i_gnt", {31'd0, i_gnt_o}, {31'd0, ei});
      chk("d_gnt", {31'd0, d_gnt_o}, {31'd0, ed});
      if (i_gnt_o) begin
        last_streak = d_streak;
        d_streak    = 0;
      end else if (d_gnt_o && i_req_i) begin
        d_streak++;
      end else begin
        d_streak = 0;
      end
      if (ei || ed) begin
        a   = ei ? ia : da;
        inr = (a < RAM_SIZE);
        chk("ram_req", {31'd0, ram_req_o}, {31'd0, inr});
        if (inr) begin
          chk("ram_addr",  ram_addr_o, a);
          chk("ram_we",    {31'd0, ram_we_o}, {31'd0, ed && dwe});
          chk("ram_be",    {28'd0, ram_be_o}, {28'd0, ei ? 4'hF : dbe});
          chk("ram_wdata", ram_wdata_o, ei ? 32'd0 : dwd);
        end
        e.due  = cyc + 1;
        e.is_d = ed;
        e.err  = !inr;
        e.data = (inr && (ei || !dwe)) ? gold[a[AW+1:2]] : 32'd0;
        sbq.push_back(e);
        if (ed && dwe && inr)
          for (int b = 0; b < 4; b++)
            if (dbe[b]) gold[a[AW+1:2]][b*8 +: 8] = dwd[b*8 +: 8];
        if (ei) ip = 0; else dp = 0;
      end else begin
        chk("idle_ram_req", {31'd0, ram_req_o}, 32'd0);
      end
      if (ip) lost = (lost < STARVE_LIMIT) ? lost + 1 : lost;
      else    lost = 0;
    end
  endtask

  initial begin
    for (int w = 0; w < RAM_WORDS; w++) gold[w] = $urandom;
    rst_v = 1;
    repeat (3) cycle();
    load_en = 0;
    rst_v   = 0;

    // Data write, first cycle out of reset, then an out-of-range read.
    set_d(1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
    cycle();
    set_d(0, 4'hF, 32'h100, 32'h0);
    cycle();
    cycle();

    // Back-to-back instruction fetches.
    set_i(32'h0); cycle();
    set_i(32'h4); cycle();
    set_i(32'h8); cycle();
    cycle();

    // Constant contention: the instruction port must win on the fifth cycle.
    last_streak = -1;
    set_i(32'h40);
    for (int k = 0; k < 6; k++) begin
      if (!dp) set_d(0, 4'hF, rnd_addr(), $urandom);
      cycle();
    end
    chk("starve_streak", last_streak, STARVE_LIMIT);
    dp = 0;
    cycle();

    // Reset right after a data grant while the instruction port is starving.
    set_i(32'h10);
    for (int k = 0; k < 2; k++) begin
      if (!dp) set_d(0, 4'hF, 32'h30, 32'h0);
      cycle();
    end
    rst_v = 1;
    cycle();
    cycle();
    rst_v = 0;
    last_streak = -1;
    for (int k = 0; k < 6; k++) begin
      if (!dp) set_d(1, 4'($urandom), rnd_addr(), $urandom);
      cycle();
    end
    chk("post_rst_streak", last_streak, STARVE_LIMIT);

    // Random interleaved traffic.
    for (int k = 0; k < 400; k++) begin
      if (!ip && $urandom_range(0, 2) != 0) set_i(rnd_addr());
      if (!dp && $urandom_range(0, 2) != 0) set_d(1'($urandom), 4'($urandom), rnd_addr(), $urandom);
      cycle();
    end

    ip = 0;
    dp = 0;
    repeat (3) cycle();
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
